// File: rtl/jtag_seq_master.sv
// jtag_seq_master: word-level JTAG sequencer driving tck/trst_n/tms/tdi for tap_core and
// collecting tdo into a response word; tck is a registered divide of clk.
module jtag_seq_master #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              trst_n,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_RUNI  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET_SEQ, S_PRE, S_SHIFT, S_POST, S_RUNI, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    idx_q, idx_d, len_q, len_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic                tck_q, tck_d, trst_n_q, trst_n_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic                accept, active, period_end, sample;
  logic [LEN_W-1:0]    len_clamped, pre_last, len_last, len_last_d;
  logic [DATA_W-1:0]   data_shr;

  // Sequencing: a period counter (idx) per state, advanced at the clk edge that ends a tck period.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    op_d    = op_q;
    data_d  = data_q;
    cap_d   = cap_q;

    len_clamped = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
    accept      = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;
    active      = (state_q inside {S_RESET_SEQ, S_PRE, S_SHIFT, S_POST}) ||
                  ((state_q == S_RUNI) && (len_q != '0));
    period_end  = active && (div_q == DIV_LAST);
    sample      = active && (state_q == S_SHIFT) && (div_q == DIV_RISE);
    pre_last    = (op_q == OP_IR) ? LEN_W'(3) : LEN_W'(2);
    len_last    = len_q - LEN_W'(1);
    div_d       = (active && !period_end) ? div_q + DIV_W'(1) : '0;

    if (sample) cap_d = cap_q | (DATA_W'(tdo) << idx_q);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          len_d  = len_clamped;
          data_d = cmd_data;
          cap_d  = '0;
          idx_d  = '0;
          if (cmd_op == OP_RESET)         state_d = S_RESET_SEQ;
          else if (len_clamped == '0)     state_d = S_RUNI;
          else if (cmd_op == OP_RUNI)     state_d = S_RUNI;
          else                            state_d = S_PRE;
        end
      end
      S_RESET_SEQ: if (period_end) begin
        if (idx_q == LEN_W'(5)) state_d = S_DONE;
        else                    idx_d   = idx_q + LEN_W'(1);
      end
      S_PRE: if (period_end) begin
        if (idx_q == pre_last) begin
          state_d = S_SHIFT;
          idx_d   = '0;
        end else idx_d = idx_q + LEN_W'(1);
      end
      S_SHIFT: if (period_end) begin
        if (idx_q == len_last) begin
          state_d = S_POST;
          idx_d   = '0;
        end else idx_d = idx_q + LEN_W'(1);
      end
      S_POST: if (period_end) begin
        if (idx_q == LEN_W'(1)) state_d = S_DONE;
        else                    idx_d   = idx_q + LEN_W'(1);
      end
      S_RUNI: begin
        // A zero-length command parks here for one cycle so completion lands 2 cycles after acceptance.
        if (len_q == '0) state_d = S_DONE;
        else if (period_end) begin
          if (idx_q == len_last) state_d = S_DONE;
          else                   idx_d   = idx_q + LEN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values derive from the upcoming state/period, so they only move at period starts.
  always_comb begin
    tms_d      = tms_q;
    tdi_d      = 1'b0;
    trst_n_d   = 1'b1;
    len_last_d = len_d - LEN_W'(1);
    data_shr   = data_d >> idx_d;
    tck_d      = active && (div_d >= DIV_HIGH);

    case (state_d)
      S_RESET_SEQ: begin
        tms_d    = (idx_d != LEN_W'(5));
        trst_n_d = (idx_d >= LEN_W'(2));
      end
      S_PRE:   tms_d = (op_d == OP_IR) ? (idx_d < LEN_W'(2)) : (idx_d == '0);
      S_SHIFT: begin
        tms_d = (idx_d == len_last_d);
        tdi_d = data_shr[0];
      end
      S_POST:  tms_d = (idx_d == '0);
      S_RUNI:  if (len_d != '0) tms_d = 1'b0;
      default: ;
    endcase

    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rsp_data_d  = ((state_d == S_DONE) && (op_q inside {OP_IR, OP_DR})) ? cap_q : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      div_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      tck_q       <= 1'b0;
      trst_n_q    <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      div_q       <= div_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      tck_q       <= tck_d;
      trst_n_q    <= trst_n_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tck       = tck_q;
  assign trst_n    = trst_n_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_seq_master.sv
// tb_jtag_seq_master: directed test of jtag_seq_master against a small behavioural TAP
// (4-bit IR, 1-bit bypass DR) with immediate-assertion checks.
module tb_jtag_seq_master;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_RUNI  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, tck, trst_n, tms, tdi;
  logic        tdo = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  jtag_seq_master #(.DATA_W(32), .LEN_W(6), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // Behavioural TAP controller standing in for tap_core.
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_e;

  tap_e       tap_st = TLR;
  logic [3:0] ir_sr = 4'd0;
  logic [3:0] ir = 4'd0;
  logic       bypass = 1'b0;

  function automatic tap_e tapNext(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap_st <= TLR;
      ir     <= 4'b0001;
    end else begin
      case (tap_st)
        CAPDR:   bypass <= 1'b0;
        SHDR:    bypass <= tdi;
        CAPIR:   ir_sr  <= 4'b0001;
        SHIR:    ir_sr  <= {tdi, ir_sr[3:1]};
        UPIR:    ir     <= ir_sr;
        default: ;
      endcase
      tap_st <= tapNext(tap_st, tms);
    end
  end

  always @(negedge tck) begin
    tdo <= (tap_st == SHDR) ? bypass : (tap_st == SHIR) ? ir_sr[0] : 1'b0;
  end

  // Event monitors: tck rising edges with the tms seen at each, handshakes and pulses per clk.
  int          rise_cnt = 0;
  logic [63:0] tms_hist = 64'd0;
  int          cyc = 0, acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0, rsp_cyc = 0, trst_lo = 0;

  always @(posedge tck) begin
    rise_cnt <= rise_cnt + 1;
    tms_hist <= {tms_hist[62:0], tms};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
    if (rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_cyc <= cyc;
    end
    if (!trst_n) trst_lo <= trst_lo + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command, waits for its response and reports tck edges, pulses, latency and trst_n-low cycles.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [5:0] len,
                               input logic [31:0] data, output int edges, output int pulses,
                               output int lat, output int trst_cycles);
    int guard, r0, p0, t0;
    @(negedge clk);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    r0 = rise_cnt; p0 = rsp_cnt; t0 = trst_lo;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput({tag, "_busy_after_accept"}, {62'd0, busy, cmd_ready}, 64'b10);
    guard = 0;
    while (rsp_cnt == p0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_completed"}, 64'(rsp_cnt != p0), 64'd1);
    edges = rise_cnt - r0;
    lat = rsp_cyc - acc_cyc;
    trst_cycles = trst_lo - t0;
    repeat (3) @(negedge clk);
    pulses = rsp_cnt - p0;
  endtask

  initial begin
    int edges, pulses, lat, tlo, guard, r0, a0, p0, first_rsp;

    $display("[TB] start");
    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    checkOutput("reset_pins", {57'd0, tck, trst_n, tms, tdi, cmd_ready, busy, rsp_valid}, 64'b0010000);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_reset_ready", {62'd0, trst_n, cmd_ready}, 64'b11);

    // TAP_RESET
    applyStimulus("tap_reset", OP_RESET, 6'd0, 32'd0, edges, pulses, lat, tlo);
    checkOutput("tap_reset_edges", 64'(edges), 64'd6);
    checkOutput("tap_reset_tms", tms_hist & 64'h3F, 64'h3E);
    checkOutput("tap_reset_trst_low", 64'(tlo), 64'd8);
    checkOutput("tap_reset_pulses", 64'(pulses), 64'd1);
    checkOutput("tap_reset_state", 64'(tap_st), 64'(RTI));
    checkOutput("tap_reset_rsp", 64'(rsp_data), 64'd0);

    // SHIFT_DR 8 bits through bypass: response is bypass 0 then 0xA5[6:0].
    applyStimulus("dr8", OP_DR, 6'd8, 32'h0000_00A5, edges, pulses, lat, tlo);
    checkOutput("dr8_edges", 64'(edges), 64'd13);
    checkOutput("dr8_tms", tms_hist & 64'h1FFF, 64'h1006);
    checkOutput("dr8_rsp", 64'(rsp_data), 64'h4A);
    checkOutput("dr8_pulses", 64'(pulses), 64'd1);
    checkOutput("dr8_tap_state", 64'(tap_st), 64'(RTI));

    // SHIFT_IR 4 bits of ones; capture pattern 0001 comes back.
    applyStimulus("ir4", OP_IR, 6'd4, 32'h0000_000F, edges, pulses, lat, tlo);
    checkOutput("ir4_edges", 64'(edges), 64'd10);
    checkOutput("ir4_tms", tms_hist & 64'h3FF, 64'h306);
    checkOutput("ir4_ir_value", 64'(ir), 64'hF);
    checkOutput("ir4_rsp", 64'(rsp_data), 64'h1);

    // Over-length DR is clamped to 32 bits.
    applyStimulus("dr_clamp", OP_DR, 6'd40, 32'h1234_5678, edges, pulses, lat, tlo);
    checkOutput("dr_clamp_edges", 64'(edges), 64'd37);
    checkOutput("dr_clamp_tms", tms_hist & 64'h1F_FFFF_FFFF, 64'h10_0000_0006);
    checkOutput("dr_clamp_rsp", 64'(rsp_data), 64'h2468_ACF0);

    // Zero-length shift: no tck, response two cycles after acceptance, data cleared.
    applyStimulus("dr_zero", OP_DR, 6'd0, 32'hFFFF_FFFF, edges, pulses, lat, tlo);
    checkOutput("dr_zero_edges", 64'(edges), 64'd0);
    checkOutput("dr_zero_latency", 64'(lat), 64'd2);
    checkOutput("dr_zero_rsp", 64'(rsp_data), 64'd0);
    checkOutput("dr_zero_pulses", 64'(pulses), 64'd1);

    // Back-to-back: RUN_IDLE 3 then SHIFT_DR 1 with cmd_valid held throughout.
    @(negedge clk);
    cmd_op = OP_RUNI; cmd_len = 6'd3; cmd_data = 32'd0; cmd_valid = 1'b1;
    r0 = rise_cnt; a0 = acc_cnt; p0 = rsp_cnt;
    @(negedge clk);
    cmd_op = OP_DR; cmd_len = 6'd1; cmd_data = 32'd1;
    guard = 0;
    while (rsp_cnt == p0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b2b_first_done", 64'(rsp_cnt - p0), 64'd1);
    checkOutput("b2b_busy_ignored", 64'(acc_cnt - a0), 64'd1);
    checkOutput("b2b_runi_edges", 64'(rise_cnt - r0), 64'd3);
    checkOutput("b2b_runi_tms", tms_hist & 64'h7, 64'h0);
    first_rsp = rsp_cyc;
    r0 = rise_cnt;
    guard = 0;
    while ((acc_cnt - a0) < 2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b0;
    checkOutput("b2b_gap", 64'(acc_cyc - first_rsp), 64'd1);
    guard = 0;
    while (rsp_cnt == p0 + 1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b2b_dr1_edges", 64'(rise_cnt - r0), 64'd6);
    checkOutput("b2b_dr1_rsp", 64'(rsp_data), 64'd0);

    // Reset in the middle of shift bit 5 of a 16-bit DR.
    @(negedge clk);
    cmd_op = OP_DR; cmd_len = 6'd16; cmd_data = 32'h0000_FFFF; cmd_valid = 1'b1;
    r0 = rise_cnt; p0 = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while ((rise_cnt - r0) < 9 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("abort_reached_bit5", 64'(rise_cnt - r0), 64'd9);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_pins", {59'd0, tck, trst_n, tms, busy, rsp_valid}, 64'b00100);
    checkOutput("abort_rsp_data", 64'(rsp_data), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_rsp", 64'(rsp_cnt - p0), 64'd0);

    applyStimulus("recover_reset", OP_RESET, 6'd0, 32'd0, edges, pulses, lat, tlo);
    checkOutput("recover_reset_state", 64'(tap_st), 64'(RTI));
    applyStimulus("recover_dr8", OP_DR, 6'd8, 32'h0000_003C, edges, pulses, lat, tlo);
    checkOutput("recover_dr8_edges", 64'(edges), 64'd13);
    checkOutput("recover_dr8_rsp", 64'(rsp_data), 64'h78);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
